vector_mem_streamer: RTL

- Read-side counterpart of the writeback stage's data-memory write path.
- Once started, it reads a run of vector words out of data memory through a synchronous read port.
- It serializes each word lane by lane onto an 8-bit valid/ready byte stream toward the host/debug link.
- Used to dump processed results (e.g. image buffers) after the vector core finishes.

---
 rtl/vector_mem_streamer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vector_mem_streamer.sv
// Reads a run of vector words from a synchronous-read data memory and
// serializes each word lane by lane onto a valid/ready byte stream.
module vector_mem_streamer #(
   parameter int unsigned vecSize      = 4,
   parameter int unsigned registerSize = 16,
   parameter int unsigned dataSize     = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [registerSize-1:0]     base_addr,
   input  logic [registerSize-1:0]     length,
   output logic [registerSize-1:0]     mem_addr,
   input  logic [vecSize*dataSize-1:0] mem_read_data,
   output logic [dataSize-1:0]         out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        busy,
   output logic                        done
);

   localparam int unsigned laneW = (vecSize > 1) ? $clog2(vecSize) : 1;
   localparam int unsigned wordW = vecSize * dataSize;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ISSUE   = 3'd1;
   localparam logic [2:0] CAPTURE = 3'd2;
   localparam logic [2:0] SEND    = 3'd3;
   localparam logic [2:0] FINISH  = 3'd4;

   localparam logic [laneW-1:0] lastLane = laneW'(vecSize - 1);

   logic [2:0]              state,    stateNext;
   logic [registerSize-1:0] addrCnt,  addrNext;
   logic [registerSize-1:0] wordCnt,  wordNext;
   logic [laneW-1:0]        laneCnt,  laneNext;
   logic [wordW-1:0]        holdReg,  holdNext;
   logic [registerSize-1:0] memAddrNext;
   logic [dataSize-1:0]     outDataNext;
   logic                    outValidNext, busyNext, doneNext;
   logic [laneW-1:0]        laneInc;
   logic [registerSize-1:0] addrInc;

   // State, counters and all outputs are registered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         addrCnt   <= '0;
         wordCnt   <= '0;
         laneCnt   <= '0;
         holdReg   <= '0;
         mem_addr  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= stateNext;
         addrCnt   <= addrNext;
         wordCnt   <= wordNext;
         laneCnt   <= laneNext;
         holdReg   <= holdNext;
         mem_addr  <= memAddrNext;
         out_data  <= outDataNext;
         out_valid <= outValidNext;
         busy      <= busyNext;
         done      <= doneNext;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      stateNext    = state;
      addrNext     = addrCnt;
      wordNext     = wordCnt;
      laneNext     = laneCnt;
      holdNext     = holdReg;
      memAddrNext  = mem_addr;
      outDataNext  = out_data;
      outValidNext = out_valid;
      busyNext     = busy;
      doneNext     = 1'b0;
      laneInc      = laneCnt + laneW'(1);
      addrInc      = addrCnt + registerSize'(vecSize);

      case (state)
         IDLE: begin
            if (start) begin
               addrNext  = base_addr;
               wordNext  = length;
               busyNext  = 1'b1;
               stateNext = ISSUE;
               // A zero-length run passes through ISSUE without touching memory
               if (length != '0) memAddrNext = base_addr;
            end
         end
         ISSUE: begin
            if (wordCnt == '0) begin
               stateNext = FINISH;
               busyNext  = 1'b0;
               doneNext  = 1'b1;
            end else begin
               stateNext = CAPTURE;
            end
         end
         CAPTURE: begin
            holdNext     = mem_read_data;
            laneNext     = '0;
            outDataNext  = mem_read_data[dataSize-1:0];
            outValidNext = 1'b1;
            stateNext    = SEND;
         end
         SEND: begin
            if (out_valid && out_ready) begin
               if (laneCnt == lastLane) begin
                  outValidNext = 1'b0;
                  wordNext     = wordCnt - registerSize'(1);
                  addrNext     = addrInc;
                  if (wordCnt == registerSize'(1)) begin
                     stateNext = FINISH;
                     busyNext  = 1'b0;
                     doneNext  = 1'b1;
                  end else begin
                     stateNext   = ISSUE;
                     memAddrNext = addrInc;
                  end
               end else begin
                  laneNext    = laneInc;
                  outDataNext = holdReg[32'(laneInc) * dataSize +: dataSize];
               end
            end
         end
         FINISH: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

endmodule
